// File: rtl/b01_stim_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | b01_stim_sequencer: plays an opcode RAM into b01, streams indexed responses |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module b01_stim_sequencer #(
  parameter int DEPTH = 11,
  parameter int AW    = 4,
  parameter int OP_W  = 3,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [OP_W-1:0]  load_data,
  input  logic [AW:0]      prog_len,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             line1,
  output logic             line2,
  output logic             obs,
  output logic [AW:0]      pc_out,
  input  logic             dut_outp,
  input  logic             dut_overflw,
  output logic             resp_valid,
  output logic [1:0]       resp_data,
  output logic [AW:0]      resp_index,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [AW:0]      DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]      ONE_A   = (AW+1)'(1);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [1:0]      state;
  logic [AW:0]     pc;
  logic [AW:0]     n_len;
  logic [1:0]      drain_cnt;
  logic            stim_valid;
  logic            pipe_valid;
  logic [AW:0]     pipe_index;
  logic [AW:0]     n_eff;
  logic [OP_W-1:0] ram [DEPTH];

  assign n_eff = (prog_len > DEPTH_C) ? DEPTH_C : prog_len;

  // Program RAM is never reset; writes only land while idle and in range.
  always_ff @(posedge clock) begin
    if (load_en && (state == IDLE) && ({1'b0, load_addr} < DEPTH_C))
      ram[load_addr] <= load_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      line1      <= 1'b0;
      line2      <= 1'b0;
      obs        <= 1'b0;
      pc_out     <= '0;
      pc         <= '0;
      n_len      <= '0;
      drain_cnt  <= '0;
      stim_valid <= 1'b0;
      pipe_valid <= 1'b0;
      pipe_index <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_index <= '0;
      ovf_count  <= '0;
    end else begin
      // Two-stage response pipe: b01 registers the stimulus, then we sample it.
      pipe_valid <= stim_valid;
      pipe_index <= pc_out;
      resp_valid <= pipe_valid;
      if (pipe_valid) begin
        resp_data  <= {dut_overflw, dut_outp};
        resp_index <= pipe_index;
      end
      if (resp_valid && resp_data[1] && (ovf_count != '1))
        ovf_count <= ovf_count + ONE_C;

      case (state)
        IDLE: begin
          {obs, line2, line1} <= 3'b000;
          stim_valid <= 1'b0;
          if (start) begin
            n_len     <= n_eff;
            ovf_count <= '0;
            pc        <= '0;
            if (n_eff == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          obs        <= ram[pc[AW-1:0]][2];
          line2      <= ram[pc[AW-1:0]][1];
          line1      <= ram[pc[AW-1:0]][0];
          pc_out     <= pc;
          stim_valid <= 1'b1;
          pc         <= pc + ONE_A;
          if (pc == n_len - ONE_A) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          {obs, line2, line1} <= 3'b000;
          stim_valid <= 1'b0;
          drain_cnt  <= drain_cnt + 2'd1;
          if (drain_cnt == 2'd2) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_b01_stim_sequencer.sv
`default_nettype none
// Self-checking bench for b01_stim_sequencer with a cycle-indexed trace model.
module tb_b01_stim_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load_en = 1'b0;
  logic [3:0] load_addr = '0;
  logic [2:0] load_data = '0;
  logic [4:0] prog_len = '0;
  logic       start = 1'b0;
  logic       busy, done, line1, line2, obs, resp_valid;
  logic [4:0] pc_out, resp_index;
  logic [1:0] resp_data;
  logic       dut_outp = 1'b0;
  logic       dut_overflw = 1'b0;
  logic [7:0] ovf_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] ram_m [0:10];

  b01_stim_sequencer #(.DEPTH(11), .AW(4), .OP_W(3), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .prog_len(prog_len), .start(start), .busy(busy),
    .done(done), .line1(line1), .line2(line2), .obs(obs), .pc_out(pc_out),
    .dut_outp(dut_outp), .dut_overflw(dut_overflw), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_index(resp_index), .ovf_count(ovf_count)
  );

  always #5 clock = ~clock;

  task automatic load(input int addr, input logic [2:0] data);
    @(negedge clock);
    load_en = 1'b1; load_addr = 4'(addr); load_data = data;
    @(negedge clock);
    load_en = 1'b0;
    if (addr < 11) ram_m[addr] = data;
  endtask

  // Cycle c counts clock edges after the one that accepted start.
  task automatic play(input int plen, input int mode, input bit disturb);
    int n, done_c, exp_ovf;
    logic [2:0] el;
    logic [1:0] drv [0:40];
    logic [3:0] ctl, ectl;
    n = (plen > 11) ? 11 : plen;
    done_c = (n == 0) ? 1 : n + 4;
    exp_ovf = 0;
    @(negedge clock);
    start = 1'b1; prog_len = 5'(plen);
    @(negedge clock);
    start = 1'b0;
    for (int c = 1; c <= done_c + 1; c++) begin
      el = (c >= 2 && c <= n + 1) ? ram_m[c-2] : 3'b000;
      n_checks++;
      if ({obs, line2, line1} !== el) begin
        n_fail++;
        $display("FAIL lines c=%0d len=%0d: got %b want %b", c, plen, {obs, line2, line1}, el);
      end
      if (c >= 2 && c <= n + 1) begin
        n_checks++;
        if (pc_out !== 5'(c-2)) begin
          n_fail++;
          $display("FAIL pc_out c=%0d: got %0d want %0d", c, pc_out, c-2);
        end
      end
      ctl  = {busy, done, resp_valid, 1'b0};
      ectl = {(n > 0 && c <= n + 3), (c == done_c), (n > 0 && c >= 4 && c <= n + 3), 1'b0};
      n_checks++;
      if (ctl !== ectl) begin
        n_fail++;
        $display("FAIL ctrl{busy,done,rv} c=%0d len=%0d: got %b want %b", c, plen, ctl[3:1], ectl[3:1]);
      end
      if (n > 0 && c >= 4 && c <= n + 3) begin
        n_checks++;
        if (resp_index !== 5'(c-4) || resp_data !== drv[c-1]) begin
          n_fail++;
          $display("FAIL resp c=%0d: got idx %0d data %b want idx %0d data %b",
                   c, resp_index, resp_data, c-4, drv[c-1]);
        end
        if (drv[c-1][1]) exp_ovf++;
      end
      if (c == 1 || c == done_c) begin
        n_checks++;
        if (ovf_count !== 8'((c == 1 && n > 0) ? 0 : exp_ovf)) begin
          n_fail++;
          $display("FAIL ovf_count c=%0d: got %0d want %0d", c, ovf_count, (c == 1 && n > 0) ? 0 : exp_ovf);
        end
      end
      dut_outp    = 1'($urandom);
      dut_overflw = (mode == 1) ? (c == 4 || c == 5) : 1'($urandom);
      drv[c] = {dut_overflw, dut_outp};
      if (disturb && n > 0 && c <= n + 3) begin
        start = 1'b1; prog_len = 5'($urandom_range(1, 15));
        load_en = 1'b1; load_addr = 4'($urandom); load_data = 3'($urandom);
      end else begin
        start = 1'b0; load_en = 1'b0;
      end
      @(negedge clock);
    end
    start = 1'b0; load_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({busy, done, line1, line2, obs, resp_valid, pc_out, resp_data, resp_index, ovf_count} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got busy=%b done=%b lines=%b rv=%b pc=%0d rd=%b ri=%0d ovf=%0d want all 0",
               busy, done, {obs, line2, line1}, resp_valid, pc_out, resp_data, resp_index, ovf_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    load(0, 3'b001); load(1, 3'b010); load(2, 3'b111); load(3, 3'b000);
    play(4, 0, 1'b0);
  endtask

  task automatic test_ovf_count();
    play(4, 1, 1'b0);
    n_checks++;
    if (ovf_count !== 8'd2) begin
      n_fail++;
      $display("FAIL ovf_after_done: got %0d want 2", ovf_count);
    end
    play(3, 0, 1'b0);
  endtask

  task automatic test_zero_len();
    play(0, 0, 1'b0);
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 11; i++) load(i, 3'($urandom));
    play(15, 0, 1'b0);
  endtask

  task automatic test_reset_midrun();
    @(negedge clock);
    start = 1'b1; prog_len = 5'd6;
    @(negedge clock);
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      dut_outp = 1'($urandom); dut_overflw = 1'b1;
      if (c == 4) reset = 1'b1;
      @(negedge clock);
    end
    n_checks++;
    if ({busy, done, line1, line2, obs, resp_valid, pc_out, resp_data, resp_index, ovf_count} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: got busy=%b done=%b lines=%b rv=%b pc=%0d ovf=%0d want all 0",
               busy, done, {obs, line2, line1}, resp_valid, pc_out, ovf_count);
    end
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      n_checks++;
      if ({busy, done, resp_valid, line1, line2, obs} !== 6'b0) begin
        n_fail++;
        $display("FAIL post_reset_quiet c=%0d: got %b want 000000", c, {busy, done, resp_valid, line1, line2, obs});
      end
    end
    play(6, 0, 1'b0);
  endtask

  task automatic test_ignore();
    load(12, 3'b111);
    load(11, 3'b101);
    play(5, 0, 1'b1);
    play(7, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int w = 0; w < 4; w++) load($urandom_range(0, 15), 3'($urandom));
      play($urandom_range(0, 15), 0, 1'($urandom));
    end
  endtask

  initial begin
    for (int i = 0; i < 11; i++) ram_m[i] = 3'b000;
    test_reset();
    for (int i = 0; i < 11; i++) load(i, 3'b000);
    test_basic();
    test_ovf_count();
    test_zero_len();
    test_clamp();
    test_reset_midrun();
    test_ignore();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/b01_stim_sequencer.md
Name: b01_stim_sequencer

Overview:
Synthesizable stimulus sequencer that sits directly upstream of the b01 core. It replaces the behavioural program-counter stimulus driver. A small opcode RAM is loaded over a write port. On start, the block steps a program counter through the RAM and drives line1/line2/__obs into b01 one opcode per clock. One cycle after each stimulus, it samples b01's outp/overflw and streams them back as indexed response beats, so the concolic flow can record traces on silicon or in emulation.

Parameters:
DEPTH, 11, number of opcode entries in the program RAM
AW, 4, address/pc width; must satisfy 2**AW >= DEPTH
OP_W, 3, opcode width; bit0=line1, bit1=line2, bit2=__obs (fixed encoding)
CNT_W, 8, width of the overflow event counter

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  synchronous, active-high reset
load_en  in  1  write strobe for program RAM
load_addr  in  AW  RAM write address
load_data  in  OP_W  RAM write data (opcode)
prog_len  in  AW+1  number of opcodes to play; sampled on accepted start
start  in  1  start request; accepted only in IDLE
busy  out  1  high from the cycle after an accepted start through the last resp_valid
done  out  1  one-cycle pulse the cycle after the last response
line1  out  1  to b01 line1, registered
line2  out  1  to b01 line2, registered
obs  out  1  to b01 __obs, registered
pc_out  out  AW+1  index of the stimulus currently driven on line1/line2/obs
dut_outp  in  1  from b01 outp
dut_overflw  in  1  from b01 overflw
resp_valid  out  1  response beat strobe, registered
resp_data  out  2  {overflw, outp} sampled for resp_index
resp_index  out  AW+1  stimulus index this response answers
ovf_count  out  CNT_W  saturating count of responses with overflw=1; cleared on accepted start

Behaviour:
- Reset (synchronous): state=IDLE; busy, done, line1, line2, obs, resp_valid=0; pc_out, resp_index, resp_data=0; ovf_count=0. The RAM is not cleared.
- RAM write: when load_en=1 and load_addr<DEPTH, write on the clock edge. Writes are ignored when load_addr>=DEPTH or the state is not IDLE.
- States: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE: lines=0. When start=1:
  - latch N=min(prog_len, DEPTH);
  - clear ovf_count;
  - if N=0, go to DONE (no stimuli, no responses); otherwise go to RUN with pc=0.
- RUN: each cycle, register ram[pc] onto {obs,line2,line1} and set pc_out=pc, then increment pc. After pc=N-1 is issued, go to DRAIN.
  - Stimulus k is driven during cycle S+k, where S is the first RUN output cycle.
- Response capture:
  - At the end of cycle S+k+1, sample {dut_overflw, dut_outp}.
  - resp_valid=1, resp_data=sample and resp_index=k are presented during cycle S+k+2.
  - Response latency is exactly 2 cycles from stimulus, giving one beat per cycle with no gaps.
- DRAIN: lines=0; wait 2 cycles for the last response; go to DONE.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- ovf_count increments on each resp_valid with resp_data[1]=1 and saturates at 2**CNT_W-1.
- start while not IDLE is ignored. prog_len>DEPTH is clamped to DEPTH.
- Reset mid-run aborts immediately to IDLE with all outputs at reset values. No done pulse and no further resp_valid.

Test Plan:
- Load ram[0..3]={001,010,111,000}, prog_len=4, start -> lines show 001,010,111,000 on consecutive cycles; pc_out 0..3; resp_index 0..3 contiguous; done 1 cycle after index 3; busy deasserts with done.
- Hold dut_overflw=1 for responses 1 and 2 of a 4-opcode run -> ovf_count=2 after done; a second start clears it to 0.
- prog_len=0, start -> done pulses 1 cycle later; no resp_valid; lines stay 0.
- prog_len=15 with DEPTH=11 -> exactly 11 stimuli and 11 responses, last resp_index=10.
- Assert reset at the 3rd RUN cycle -> next cycle all outputs=0, state IDLE, no done. A re-start replays the program from pc=0 with RAM intact.
- Pulse load_en and start while busy, and write load_addr=12 -> RAM unchanged, run unaffected, no restart.
